// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry block.
//   - Key codes of the function keys (row*4 + col).
//   - FSM state enum for the press/debounce/release sequencer.
//   - Digit limits for positive and negative entries.
//   - Small helpers that classify a column read.
package keypad_pkg;

  localparam logic [3:0] KEY_SIGN = 4'd10;
  localparam logic [3:0] KEY_BS   = 4'd11;
  localparam logic [3:0] KEY_CLR  = 4'd12;
  localparam logic [3:0] KEY_ENT  = 4'd13;

  localparam int MAX_POS_DIG = 6;
  localparam int MAX_NEG_DIG = 5;

  localparam int MAG_W    = 20;
  localparam int SERIAL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACCEPT,
    HELD
  } state_t;

  // True when exactly one bit is set; two or more low columns are a ghost.
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit; only meaningful when onehot4() is true.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    if (v[1])      idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else if (v[3]) idx = 2'd3;
    else           idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix lines plus the entry outputs.
//   key_col    : column sense, active-low (driven by the keypad)
//   key_row    : row drive, active-low, one row low at a time
//   key_serial : signed 32-bit live entry value
//   key_valid  : one-cycle pulse per accepted key
//   key_code   : last accepted key code, held
//   key_enter  : one-cycle pulse when Enter is accepted
// master = keypad_entry side, slave = keypad/consumer side.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0]          key_col;
  logic [3:0]          key_row;
  logic [SERIAL_W-1:0] key_serial;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_enter;

  modport master (
    input  key_col,
    output key_row, key_serial, key_valid, key_code, key_enter
  );

  modport slave (
    output key_col,
    input  key_row, key_serial, key_valid, key_code, key_enter
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: row scanner and column sampler.
//   key_clk, key_rst : clock, async active-high reset
//   key_col          : column sense (active-low)
//   key_row          : registered row drive (active-low)
//   samp_stb         : high in the last cycle of each row slot
//   samp_row         : row being sampled
//   samp_hit         : exactly one column low in that row
//   samp_col         : the low column when samp_hit is set
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       key_clk,
  input  logic       key_rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       samp_stb,
  output logic [1:0] samp_row,
  output logic       samp_hit,
  output logic [1:0] samp_col
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       row_cnt;
  logic [1:0]       row_nxt;
  logic [3:0]       col_low;

  assign row_nxt = row_cnt + 2'd1;

  // The row drive moves on the first cycle of a slot so the column lines
  // have the rest of the slot to settle before the sample.
  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      slot_cnt <= '0;
      row_cnt  <= 2'd0;
      key_row  <= 4'b1110;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      row_cnt  <= row_nxt;
      key_row  <= ~(4'b0001 << row_nxt);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  assign col_low  = ~key_col;
  assign samp_stb = (slot_cnt == SLOT_LAST);
  assign samp_row = row_cnt;
  assign samp_hit = onehot4(col_low);
  assign samp_col = enc4(col_low);

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner, debouncer and signed decimal entry.
//   key_clk, key_rst : clock, async active-high reset
//   kp (master)      : key_col in; key_row, key_serial, key_valid,
//                      key_code, key_enter out
// A press must read identically in its row slot for DEBOUNCE_N frames to be
// accepted; the row must then read empty for DEBOUNCE_N frames before any
// new press is considered, so a held key never repeats.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic     key_clk,
  input  logic     key_rst,
  keypad_if.master kp
);

  localparam int DB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [2:0] POS_LIM = 3'(MAX_POS_DIG);
  localparam logic [2:0] NEG_LIM = 3'(MAX_NEG_DIG);

  logic            samp_stb;
  logic [1:0]      samp_row;
  logic            samp_hit;
  logic [1:0]      samp_col;
  logic [3:0]      samp_code;

  state_t          state;
  logic [3:0]      lat_code;
  logic [DB_W-1:0] stab_cnt;
  logic            own_slot;
  logic            cnt_done;

  logic            acc_go;
  logic [3:0]      acc_code;

  logic [MAG_W-1:0] mag, mag_nxt;
  logic             neg, neg_nxt;
  logic [2:0]       ndig, ndig_nxt;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .key_clk  (key_clk),
    .key_rst  (key_rst),
    .key_col  (kp.key_col),
    .key_row  (kp.key_row),
    .samp_stb (samp_stb),
    .samp_row (samp_row),
    .samp_hit (samp_hit),
    .samp_col (samp_col)
  );

  // mag*10 as (mag<<3) + (mag<<1); inputs never exceed 99999, so no overflow.
  function automatic logic [MAG_W-1:0] mul10(input logic [MAG_W-1:0] m);
    return (m << 3) + (m << 1);
  endfunction

  // Signed output; a negative sign on a zero magnitude is shown as plain 0.
  function automatic logic signed [SERIAL_W-1:0] to_serial(
    input logic n, input logic [MAG_W-1:0] m);
    logic signed [SERIAL_W-1:0] ext;
    ext = signed'({{(SERIAL_W - MAG_W){1'b0}}, m});
    return (n && (m != '0)) ? -ext : ext;
  endfunction

  assign samp_code = {samp_row, samp_col};
  assign own_slot  = samp_stb && (samp_row == lat_code[3:2]);
  assign cnt_done  = (int'(stab_cnt) + 1) >= DEBOUNCE_N;

  // Decide the accept one edge early so key_valid/key_code are registered
  // into the ACCEPT cycle itself.
  always_comb begin
    acc_go   = 1'b0;
    acc_code = lat_code;
    case (state)
      IDLE: begin
        acc_code = samp_code;
        acc_go   = samp_stb && samp_hit && (DEBOUNCE_N <= 1);
      end
      DEBOUNCE: begin
        acc_go = own_slot && samp_hit && (samp_code == lat_code) && cnt_done;
      end
      default: ;
    endcase
  end

  // Entry update applied in the ACCEPT cycle.
  always_comb begin
    mag_nxt  = mag;
    neg_nxt  = neg;
    ndig_nxt = ndig;
    if (lat_code <= 4'd9) begin
      if ((ndig < (neg ? NEG_LIM : POS_LIM)) &&
          !((ndig == 3'd0) && (lat_code == 4'd0))) begin
        mag_nxt  = mul10(mag) + {{(MAG_W - 4){1'b0}}, lat_code};
        ndig_nxt = ndig + 3'd1;
      end
    end else begin
      case (lat_code)
        KEY_SIGN: if (neg || (ndig != POS_LIM)) neg_nxt = ~neg;
        KEY_BS: begin
          if (ndig != 3'd0) begin
            mag_nxt  = mag / MAG_W'(10);
            ndig_nxt = ndig - 3'd1;
            if (ndig == 3'd1) neg_nxt = 1'b0;
          end
        end
        KEY_CLR: begin
          mag_nxt  = '0;
          neg_nxt  = 1'b0;
          ndig_nxt = 3'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      state         <= IDLE;
      lat_code      <= 4'd0;
      stab_cnt      <= '0;
      mag           <= '0;
      neg           <= 1'b0;
      ndig          <= 3'd0;
      kp.key_valid  <= 1'b0;
      kp.key_enter  <= 1'b0;
      kp.key_code   <= 4'd0;
      kp.key_serial <= '0;
    end else begin
      kp.key_valid <= acc_go;
      kp.key_enter <= acc_go && (acc_code == KEY_ENT);
      if (acc_go) kp.key_code <= acc_code;

      case (state)
        IDLE: begin
          if (samp_stb && samp_hit) begin
            lat_code <= samp_code;
            stab_cnt <= DB_W'(1);
            state    <= acc_go ? ACCEPT : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (own_slot) begin
            if (samp_hit && (samp_code == lat_code)) begin
              if (acc_go) state <= ACCEPT;
              else        stab_cnt <= stab_cnt + DB_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        ACCEPT: begin
          mag           <= mag_nxt;
          neg           <= neg_nxt;
          ndig          <= ndig_nxt;
          kp.key_serial <= to_serial(neg_nxt, mag_nxt);
          stab_cnt      <= '0;
          state         <= HELD;
        end
        HELD: begin
          // Only the latched row matters; any hit there restarts release.
          if (own_slot) begin
            if (samp_hit) begin
              stab_cnt <= '0;
            end else if (cnt_done) begin
              stab_cnt <= '0;
              state    <= IDLE;
            end else begin
              stab_cnt <= stab_cnt + DB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
